// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router switch allocator.
// Contents:
//   port_e          - port naming, index 0..4 = N, S, E, W, L
//   NUM_PORTS       - number of router ports
//   PKT_LEN_DEFAULT - default flits per packet, head included
//   NO_GRANT        - grant value reported by an idle output
//   rr_pick()       - round-robin pick starting just after the last winner
package noc_pkg;

  typedef enum logic [2:0] {
    N = 3'd0,
    S = 3'd1,
    E = 3'd2,
    W = 3'd3,
    L = 3'd4
  } port_e;

  localparam int NUM_PORTS = 5;
  localparam int PKT_LEN_DEFAULT = 5;
  localparam logic [2:0] NO_GRANT = 3'b111;

  // Scans ptr+1, ptr+2, ... (mod NUM_PORTS) and returns the first set request.
  // Returns NO_GRANT when req is empty; callers only use the result when
  // at least one request is present.
  function automatic logic [2:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                         input logic [2:0] ptr);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = NO_GRANT;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = 3'((int'(ptr) + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/out_alloc_fsm.sv
// Per-output allocation state machine: arbitrates among the candidate
// inputs, locks the winner for one packet and strobes transfers.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   cand        - inputs eligible to win this output (already masked)
//   req_valid   - per-input "flit at buffer head"
//   out_ready   - downstream of this output accepts a flit
//   grant       - locked input index, NO_GRANT when idle (registered)
//   busy        - output is locked to an input (registered)
//   out_valid   - a flit moves through this output this cycle
//   pop         - one-hot dequeue strobe toward the locked input
module out_alloc_fsm
  import noc_pkg::*;
#(
  parameter int NPORTS  = 5,
  parameter int PKT_LEN = PKT_LEN_DEFAULT,
  parameter int PW      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPORTS-1:0] cand,
  input  logic [NPORTS-1:0] req_valid,
  input  logic              out_ready,
  output logic [PW-1:0]     grant,
  output logic              busy,
  output logic              out_valid,
  output logic [NPORTS-1:0] pop
);

  typedef enum logic {IDLE, LOCKED} state_e;

  // Four bits cover packets of up to 16 flits.
  localparam int CW = 4;

  state_e        state;
  logic [PW-1:0] winner;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pick;
  logic          xfer;

  assign pick = rr_pick(cand, ptr);

  // Transfer strobe toward the locked input; only one bit can be set.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (state == LOCKED && winner == PW'(i) && req_valid[i] && out_ready)
        pop[i] = 1'b1;
    end
  end

  assign xfer      = |pop;
  assign out_valid = xfer;
  assign busy      = (state == LOCKED);
  assign grant     = winner;

  // A lock is only released after the last flit of the packet moves, so
  // stalls stretch the packet rather than abandoning it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      winner <= NO_GRANT;
      ptr    <= PW'(NPORTS - 1);
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            state  <= LOCKED;
            winner <= pick;
            ptr    <= pick;
            cnt    <= '0;
          end
        end
        LOCKED: begin
          if (xfer) begin
            if (cnt == CW'(PKT_LEN - 1)) begin
              state  <= IDLE;
              winner <= NO_GRANT;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          winner <= NO_GRANT;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_alloc.sv
// Switch allocator for the 5-port mesh router. Sits between the input
// buffers and the crossbar; each output arbitrates independently and the
// crossbar selects come straight from grant_o.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   req_valid_i  - input i has a flit at its buffer head
//   req_dst_i    - destination of input i, slice [i*PW +: PW]
//   out_ready_i  - downstream of output o accepts a flit
//   grant_o      - input driving output o, slice [o*PW +: PW], 3'b111 idle
//   busy_o       - output o is locked to an input
//   out_valid_o  - output o transfers a flit this cycle
//   in_pop_o     - input i dequeues a flit this cycle
module switch_alloc
  import noc_pkg::*;
#(
  parameter int NPORTS  = NUM_PORTS,
  parameter int PKT_LEN = PKT_LEN_DEFAULT,
  parameter int PW      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    req_valid_i,
  input  logic [NPORTS*PW-1:0] req_dst_i,
  input  logic [NPORTS-1:0]    out_ready_i,
  output logic [NPORTS*PW-1:0] grant_o,
  output logic [NPORTS-1:0]    busy_o,
  output logic [NPORTS-1:0]    out_valid_o,
  output logic [NPORTS-1:0]    in_pop_o
);

  logic [NPORTS-1:0] held;
  logic [NPORTS-1:0] cand    [NPORTS];
  logic [NPORTS-1:0] pop_per [NPORTS];

  // An input already locked to some output must not compete elsewhere:
  // its current flit is a body flit and its dst field is meaningless.
  always_comb begin
    held = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (busy_o[o] && grant_o[o*PW +: PW] == PW'(i))
          held[i] = 1'b1;
      end
    end
  end

  // Destinations 5..7 never equal an output index, so they never match.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        cand[o][i] = !held[i] && req_valid_i[i] &&
                     (req_dst_i[i*PW +: PW] == PW'(o));
      end
    end
  end

  // Each input is locked to at most one output, so the OR never merges
  // two real strobes.
  always_comb begin
    in_pop_o = '0;
    for (int o = 0; o < NPORTS; o++)
      in_pop_o = in_pop_o | pop_per[o];
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    out_alloc_fsm #(
      .NPORTS  (NPORTS),
      .PKT_LEN (PKT_LEN),
      .PW      (PW)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .cand      (cand[o]),
      .req_valid (req_valid_i),
      .out_ready (out_ready_i[o]),
      .grant     (grant_o[o*PW +: PW]),
      .busy      (busy_o[o]),
      .out_valid (out_valid_o[o]),
      .pop       (pop_per[o])
    );
  end

endmodule

// File: doc/switch_alloc.md
# switch_alloc

Switch allocator for the 5-port mesh router (N, S, E, W, L). It sits between the input buffers and the crossbar. Each output port runs its own round-robin arbitration over the inputs whose head flit targets it. The winner is locked to that output for one full packet of `PKT_LEN` flits, and the allocator issues per-cycle pop (to the input) and valid (to the output) strobes under downstream backpressure. The crossbar select lines come directly from `grant_o`.

## Interface
Parameters:
- `NPORTS`, 5: number of router ports; index 0..4 = N, S, E, W, L
- `PKT_LEN`, 5: flits per packet, head included; range 1..16
- `PW`, 3: width of a port index

Ports:
- `clk`  in  1  router clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid_i`  in  NPORTS  input i has a flit at its buffer head
- `req_dst_i`  in  NPORTS*PW  destination output of input i, slice [i*PW +: PW]; meaningful only on head flits
- `out_ready_i`  in  NPORTS  downstream of output o accepts a flit this cycle
- `grant_o`  out  NPORTS*PW  input index driving output o; 3'b111 when o is idle
- `busy_o`  out  NPORTS  output o is locked to an input
- `out_valid_o`  out  NPORTS  output o transfers a flit this cycle
- `in_pop_o`  out  NPORTS  input i transfers (dequeues) a flit this cycle

## Operation
- Each output o has two states, IDLE and LOCKED, plus a winner register, a flit counter, and a last-winner pointer `ptr[o]`.
- An input is free when no output is locked to it.
- Candidate set in IDLE: inputs that are free, have `req_valid_i` = 1, and have `req_dst_i` == o.
  - Destinations 5..7 are invalid and never match an output.
- IDLE with a non-empty candidate set:
  - Pick the first candidate in the order `ptr+1, ptr+2, …` (mod NPORTS).
  - Next state is LOCKED; winner ← pick; `ptr[o]` ← pick; counter ← 0.
- LOCKED:
  - A transfer occurs when `req_valid_i[winner] & out_ready_i[o]`.
  - On a transfer: `out_valid_o[o]` = 1, `in_pop_o[winner]` = 1, and the counter increments.
  - On the transfer where counter == `PKT_LEN-1`: next state IDLE, counter ← 0.
- No transfer happens in an IDLE cycle. `out_valid_o` and `in_pop_o` are combinational from state, `req_valid_i` and `out_ready_i`.
- `in_pop_o[i]` = OR over outputs of the per-output pop for input i. At most one bit contributes, because an input can be locked to only one output.
- Outputs arbitrate independently in the same cycle. This cannot conflict, because a free input names exactly one destination.
- An input released at cycle t (its last transfer) is free from t+1.
- Stalls never break a lock. The lock persists until `PKT_LEN` transfers complete.

## Timing
- On reset (`rst_n` = 0 at a clk edge), from the next cycle:
  - All outputs IDLE, counters 0, `ptr[o]` = NPORTS-1 (input 0 has highest priority).
  - `grant_o` = all 3'b111, `busy_o` = 0, `out_valid_o` = 0, `in_pop_o` = 0.
- Reset mid-packet aborts the lock immediately. Recovering the partial packet is the buffer's job.
- Grant latency: head flit valid at cycle t with the output IDLE and no contention → LOCKED at t+1, first transfer at t+1 at the earliest.
- Packet occupancy is at least `PKT_LEN` cycles. Each cycle with `out_ready_i` = 0 or `req_valid_i` = 0 adds one cycle.
- Back-to-back packets on one output: last transfer at t, IDLE at t+1, arbitration at t+1, next first transfer at t+2. This is a one-cycle bubble by design.
- `grant_o` and `busy_o` are registered; they change only at clk edges.

## Structure
- `noc_pkg` holds:
  - `port_e` enum (N=0, S=1, E=2, W=3, L=4)
  - `NO_GRANT` = 3'b111
  - the default `PKT_LEN`
  - the function `rr_pick(req, ptr)` returning a port index
- Sub-module `out_alloc_fsm`: one instance per output via generate. It contains the state, winner, counter and pointer for that output. The top level does candidate masking and the pop OR-reduction.

## Test plan
- Single request: input 4 (L) requests dst 2 at t0, with `out_ready_i` = all 1.
  - `grant_o[2]` = 4 from t1.
  - Five transfers t1–t5.
  - IDLE and `grant_o[2]` = 3'b111 at t6.
- Contention: inputs 1, 3, 4 request dst 2 continuously from reset.
  - Grant order 1, 3, 4, 1.
  - Exactly one bubble cycle between packets.
- Backpressure: locked on output 0; `out_ready_i[0]` = 0 for 3 cycles after the 2nd flit.
  - Grant held, no pop during the stall.
  - Packet completes 3 cycles late.
- Parallel: inputs 0→2, 1→3, 2→4 in the same cycle.
  - All three lock at t+1 and transfer simultaneously.
- Locked input ignored: input 0 is locked to output 2, and its body flit shows dst 3.
  - Output 3 never grants input 0.
  - Invalid dst 6 on input 1 is never granted.
- Reset mid-packet: `rst_n` = 0 after the 2nd flit.
  - All outputs are at reset values next cycle.
  - A subsequent contention starts with input 0 winning.
